pipelined_shifter: RTL
======================

Name: pipelined_shifter

Overview:
- Parametrised, optionally pipelined logarithmic barrel shifter with four modes: logical left, logical right, arithmetic right and rotate right.
- Generalises the 32-bit arithmetic-right-only combinational shifter to any power-of-two width.
- Register placement between mux levels is configurable. A valid/ready handshake provides back-pressure.
- Sits between the ALU operand muxes and the result writeback mux, and serves sll/srl/sra/ror.

Parameters:
- WIDTH, 32, data width in bits; must be a power of two, at least 2.
- SHAMT_W, log2(WIDTH), shift-amount width; derived, do not override.
- STAGE_REG, all-zero SHAMT_W-bit vector, register-placement mask.
  - Bit k set places a pipeline register after mux level k (level k shifts by 2^k).
  - Latency L = popcount(STAGE_REG).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserts when 0).
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHAMT_W  shift amount, 0..WIDTH-1.
- in_op  in  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted result.
- out_zero  out  1  out_data equals 0.

Behaviour:
- Datapath:
  - SHAMT_W mux levels, applied in order k = 0..SHAMT_W-1. Level k shifts by 2^k when shamt bit k is 1, otherwise passes through.
  - SLL fills the vacated LSBs with 0. SRL fills the vacated MSBs with 0.
  - SRA fills the vacated MSBs with bit WIDTH-1 of the original operand. The sign travels down the pipeline with the data.
  - ROR wraps the bits shifted out at the LSB into the MSBs.
  - shamt = 0 returns in_data unchanged in all modes.
- Pipeline carriage: each pipeline register holds the partial result, the remaining shamt bits, op, the original sign and a valid bit.
- Handshake:
  - advance = !out_valid || out_ready. in_ready = advance.
  - A transfer into the pipe occurs when in_valid && in_ready.
  - While advance is 1, every stage register loads from its upstream stage. Valid bits load the upstream valid; stage 0 loads in_valid.
  - While advance is 0, all stage registers, including data, hold their values.
  - Bubbles are not collapsed: the whole pipe stalls together.
  - Output data is stable while out_valid && !out_ready.
- Latency: exactly L cycles from input acceptance to out_valid when there is no stall. Throughput is one result per cycle with out_ready held at 1.
- L = 0:
  - Fully combinational: out_valid = in_valid, in_ready = out_ready, out_data = f(in_data, in_shamt, in_op).
  - reset has no effect in this configuration.
- Reset:
  - On reset low, all valid bits clear to 0 and all data/shamt/op registers clear to 0, asynchronously.
  - Outputs during and after reset: out_valid = 0, out_data = 0, out_zero = 1, in_ready = 1.
- Reset mid-operation: all in-flight operands are discarded. Nothing emerges after reset deasserts.
- Simultaneous events: with the pipe full and out_ready = 1, a new operand is accepted in the same cycle the oldest result is consumed.
- out_zero is combinational from out_data. It is meaningful only when out_valid = 1.
- in_shamt, in_op and in_data are sampled only on an accepted transfer. Values on cycles with in_valid = 0 do not affect later results.

Test Plan (WIDTH=32, STAGE_REG=5'b10101, L=3 unless stated):
- Reset then idle: hold reset low, release -> out_valid=0, out_data=0, out_zero=1, in_ready=1. Then drive in_valid=1 with 0x80000000 SRA 4 -> out_valid rises exactly 3 cycles after acceptance, out_data=0xF8000000.
- Mode sweep, operand 0x8000_00F1, shamt 8 -> SLL 0x0000F100, SRL 0x00800000, SRA 0xFF800000, ROR 0xF1800000. Also shamt 0 -> 0x800000F1 in all four modes. Also SRA 31 of 0x80000000 -> 0xFFFFFFFF.
- Back-to-back stream of 8 operands with out_ready=1 -> 8 consecutive out_valid cycles, results in order, no gaps.
- Back-pressure: fill the pipe, then drop out_ready for 5 cycles -> in_ready=0, out_data/out_valid held stable. On out_ready=1, results drain in order with none lost or duplicated.
- Reset mid-flight: accept 2 operands, pulse reset low for one cycle before the first emerges -> no out_valid for at least 3 cycles after release.
- Parameter variants:
  - WIDTH=8, STAGE_REG=0: 0x96 ROR 3 -> out_data=0xD2 in the same cycle, out_valid=in_valid.
  - WIDTH=64, STAGE_REG=all ones: 0x8000000000000000 SRA 63 -> all ones after exactly 6 cycles.

Source files
------------

// File: rtl/pipelined_shifter.sv
// pipelined_shifter
//   Logarithmic barrel shifter that serves sll/srl/sra/ror. It sits between the
//   ALU operand muxes and the writeback mux. Mux level k shifts by 2^k. Setting
//   STAGE_REG[k] puts a pipeline register after level k. The latency is the
//   number of set bits in STAGE_REG. When no bit is set the block is purely
//   combinational.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous reset, active low (asserts at 0)
//   in_valid   operand valid
//   in_ready   block can accept an operand this cycle
//   in_data    operand, WIDTH bits
//   in_shamt   shift amount, 0..WIDTH-1
//   in_op      00 SLL, 01 SRL, 10 SRA, 11 ROR
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_data   shifted result
//   out_zero   out_data is all zeros (meaningful only with out_valid)

module pipelined_shifter #(
  parameter int                 WIDTH     = 32,
  parameter int                 SHAMT_W   = $clog2(WIDTH),
  parameter logic [SHAMT_W-1:0] STAGE_REG = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_zero
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  function automatic int count_stages(input logic [SHAMT_W-1:0] mask);
    int n;
    n = 0;
    for (int i = 0; i < SHAMT_W; i++) n += int'(mask[i]);
    return n;
  endfunction

  localparam int LATENCY = count_stages(STAGE_REG);

  logic             advance;
  logic [WIDTH-1:0] final_data;
  logic             final_valid;

  // One block per mux level. Each block sees its operand either straight from
  // the ports (level 0), from a register after the previous level, or directly
  // from the previous level's mux. Only the shamt bits not yet consumed travel
  // onward. The original operand sign travels with the data so that SRA can
  // refill correctly after earlier levels have shifted the MSB away.
  generate
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_lvl
      localparam int SH = 1 << k;

      logic [WIDTH-1:0]     data_i;
      logic                 valid_i;
      logic [SHAMT_W-1-k:0] rem_i;
      logic [1:0]           op_i;
      logic                 sign_i;
      logic [WIDTH-1:0]     shifted;
      logic [WIDTH-1:0]     level_out;

      if (k == 0) begin : g_src
        assign data_i  = in_data;
        assign valid_i = in_valid;
        assign rem_i   = in_shamt;
        assign op_i    = in_op;
        assign sign_i  = in_data[WIDTH-1];
      end else if (STAGE_REG[k-1]) begin : g_reg
        // The whole pipe freezes together when the output is blocked. Bubbles
        // are never squeezed out.
        always_ff @(posedge clock or negedge reset) begin
          if (!reset) begin
            data_i  <= '0;
            valid_i <= 1'b0;
            rem_i   <= '0;
            op_i    <= '0;
            sign_i  <= 1'b0;
          end else if (advance) begin
            data_i  <= g_lvl[k-1].level_out;
            valid_i <= g_lvl[k-1].valid_i;
            rem_i   <= g_lvl[k-1].rem_i[SHAMT_W-k:1];
            op_i    <= g_lvl[k-1].op_i;
            sign_i  <= g_lvl[k-1].sign_i;
          end
        end
      end else begin : g_wire
        assign data_i  = g_lvl[k-1].level_out;
        assign valid_i = g_lvl[k-1].valid_i;
        assign rem_i   = g_lvl[k-1].rem_i[SHAMT_W-k:1];
        assign op_i    = g_lvl[k-1].op_i;
        assign sign_i  = g_lvl[k-1].sign_i;
      end

      // Fixed shift by 2^k in the selected mode. rem_i[0] is this level's
      // shamt bit.
      always_comb begin
        shifted = data_i;
        case (op_i)
          OP_SLL:  shifted = data_i << SH;
          OP_SRL:  shifted = data_i >> SH;
          OP_SRA:  shifted = (data_i >> SH) | ({WIDTH{sign_i}} << (WIDTH - SH));
          default: shifted = (data_i >> SH) | (data_i << (WIDTH - SH));
        endcase
        level_out = rem_i[0] ? shifted : data_i;
      end
    end

    if (STAGE_REG[SHAMT_W-1]) begin : g_out_reg
      // The last register carries only the result and valid. No control is
      // needed past the final level.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          final_data  <= '0;
          final_valid <= 1'b0;
        end else if (advance) begin
          final_data  <= g_lvl[SHAMT_W-1].level_out;
          final_valid <= g_lvl[SHAMT_W-1].valid_i;
        end
      end
    end else begin : g_out_wire
      assign final_data  = g_lvl[SHAMT_W-1].level_out;
      assign final_valid = g_lvl[SHAMT_W-1].valid_i;
    end

    // With no registers, ready passes straight through from the consumer.
    if (LATENCY == 0) begin : g_comb_hs
      assign advance = out_ready;
    end else begin : g_pipe_hs
      assign advance = !final_valid || out_ready;
    end
  endgenerate

  assign in_ready  = advance;
  assign out_valid = final_valid;
  assign out_data  = final_data;
  assign out_zero  = (final_data == '0);

endmodule
